gda_recovery_ctrl: RTL and testbench

// Multi-cycle sequencer around a GDA-style approximate adder (2-bit sub-adders, windowed carry prediction).

---
 rtl/gda_recovery_ctrl.sv | 123 ++++++++++++
 tb/tb_gda_recovery_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gda_recovery_ctrl.sv
// gda_recovery_ctrl: GDA approximate adder sequencer with iterative carry repair
module gda_recovery_ctrl #(
  parameter int W    = 8,
  parameter int BLK  = 2,
  parameter int PRED = 4,
  localparam int NB  = W / BLK,
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in1,
  input  logic [W-1:0]  in2,
  input  logic          exact_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    res,
  output logic          err_det,
  output logic          exact,
  output logic [CW-1:0] corr_cycles
);
  typedef enum logic [1:0] {IDLE, EVAL, CORR, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum;
  logic [NB-1:0] cv_q, cv_d, pred, co;
  logic [CW-1:0] cnt_q, cnt_d, corr_q, corr_d;
  logic [W:0] res_q, res_d;
  logic mode_q, mode_d, err_q, err_d, exact_q, exact_d, mm;
  assign pred[0] = 1'b0;
  // Predicted carry into block k comes from the PRED bits directly below it
  for (genvar k = 1; k < NB; k++) begin : g_pred
    localparam int LO = (k * BLK > PRED) ? k * BLK - PRED : 0;
    localparam int PW = k * BLK - LO;
    logic [PW:0] ps;
    assign ps = {1'b0, in1[k*BLK-1:LO]} + {1'b0, in2[k*BLK-1:LO]};
    assign pred[k] = ps[PW];
  end
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [BLK:0] s;
    assign s = {1'b0, a_q[k*BLK+:BLK]} + {1'b0, b_q[k*BLK+:BLK]} + {{BLK{1'b0}}, cv_q[k]};
    assign sum[k*BLK+:BLK] = s[BLK-1:0];
    assign co[k] = s[BLK];
  end
  assign mm = |(cv_q[NB-1:1] ^ co[NB-2:0]);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign res = res_q;
  assign err_det = err_q;
  assign exact = exact_q;
  assign corr_cycles = corr_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    mode_d = mode_q;
    cv_d = cv_q;
    cnt_d = cnt_q;
    res_d = res_q;
    err_d = err_q;
    exact_d = exact_q;
    corr_d = corr_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = in1;
        b_d = in2;
        mode_d = exact_mode;
        cv_d = pred;
        cnt_d = '0;
        state_d = EVAL;
      end
      EVAL: begin
        err_d = mm;
        if (!mode_q || !mm) begin
          res_d = {co[NB-1], sum};
          exact_d = !mm;
          corr_d = '0;
          state_d = DONE;
        end else begin
          cv_d = {co[NB-2:0], 1'b0};
          cnt_d = CW'(1);
          state_d = CORR;
        end
      end
      CORR: if (mm) begin
        cv_d = {co[NB-2:0], 1'b0};
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end else begin
        res_d = {co[NB-1], sum};
        exact_d = 1'b1;
        corr_d = cnt_q;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      mode_q <= 1'b0;
      cv_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      exact_q <= 1'b0;
      corr_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      mode_q <= mode_d;
      cv_q <= cv_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      err_q <= err_d;
      exact_q <= exact_d;
      corr_q <= corr_d;
    end
  end
endmodule

// File: tb/tb_gda_recovery_ctrl.sv
// tb_gda_recovery_ctrl: directed vectors for 8-bit and 16-bit sequencer instances
module tb_gda_recovery_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, sel;
  logic iv8, ir8, m8, ov8, or8, e8, x8;
  logic [7:0] a8, b8;
  logic [8:0] r8;
  logic [1:0] c8;
  logic iv16, ir16, m16, ov16, or16, e16, x16;
  logic [15:0] a16, b16;
  logic [16:0] r16;
  logic [2:0] c16;
  logic v_ir, v_ov, v_e, v_x;
  logic [16:0] v_r;
  logic [2:0] v_c;
  int n_cmp = 0, n_bad = 0;
  gda_recovery_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
    .exact_mode(m8), .out_valid(ov8), .out_ready(or8), .res(r8), .err_det(e8),
    .exact(x8), .corr_cycles(c8));
  gda_recovery_ctrl #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in1(a16), .in2(b16),
    .exact_mode(m16), .out_valid(ov16), .out_ready(or16), .res(r16), .err_det(e16),
    .exact(x16), .corr_cycles(c16));
  always_comb begin
    v_ir = sel ? ir16 : ir8;
    v_ov = sel ? ov16 : ov8;
    v_e = sel ? e16 : e8;
    v_x = sel ? x16 : x8;
    v_r = sel ? r16 : {8'b0, r8};
    v_c = sel ? c16 : {1'b0, c8};
  end
  typedef struct {
    bit mode;
    logic [7:0] a, b;
    logic [8:0] r;
    bit e, x;
    logic [2:0] c;
    int lat;
  } vec_t;
  vec_t vt[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic op(input bit s, input bit md, input logic [15:0] a, input logic [15:0] b,
                    input logic [16:0] er, input bit ee, input bit ex, input logic [2:0] ec,
                    input int el, input string nm);
    int lat;
    @(negedge clk);
    sel = s;
    if (s) begin iv16 = 1; a16 = a; b16 = b; m16 = md; end
    else begin iv8 = 1; a8 = a[7:0]; b8 = b[7:0]; m8 = md; end
    #1 chk({nm, "_in_ready"}, 32'(v_ir), 1);
    @(negedge clk);
    iv8 = 0;
    iv16 = 0;
    lat = 1;
    while (!v_ov && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_res"}, 32'(v_r), 32'(er));
    chk({nm, "_err_det"}, 32'(v_e), 32'(ee));
    chk({nm, "_exact"}, 32'(v_x), 32'(ex));
    chk({nm, "_corr"}, 32'(v_c), 32'(ec));
    or8 = 1;
    or16 = 1;
    @(negedge clk);
    or8 = 0;
    or16 = 0;
    chk({nm, "_ov_drop"}, 32'(v_ov), 0);
    chk({nm, "_back_idle"}, 32'(v_ir), 1);
  endtask
  initial begin
    int w;
    vt[0]  = '{0, 8'h0F, 8'h01, 9'h010, 0, 1, 0, 2};
    vt[1]  = '{0, 8'h3F, 8'h01, 9'h000, 1, 0, 0, 2};
    vt[2]  = '{1, 8'h3F, 8'h01, 9'h040, 1, 1, 1, 3};
    vt[3]  = '{1, 8'hFF, 8'h01, 9'h100, 1, 1, 1, 3};
    vt[4]  = '{0, 8'hFF, 8'h01, 9'h0C0, 1, 0, 0, 2};
    vt[5]  = '{1, 8'hFF, 8'hFF, 9'h1FE, 0, 1, 0, 2};
    vt[6]  = '{1, 8'h00, 8'h00, 9'h000, 0, 1, 0, 2};
    vt[7]  = '{1, 8'hAA, 8'h55, 9'h0FF, 0, 1, 0, 2};
    vt[8]  = '{0, 8'h80, 8'h80, 9'h100, 0, 1, 0, 2};
    vt[9]  = '{1, 8'h3C, 8'h04, 9'h040, 0, 1, 0, 2};
    vt[10] = '{0, 8'h30, 8'h10, 9'h040, 0, 1, 0, 2};
    sel = 0; rst_n = 0;
    iv8 = 0; a8 = 0; b8 = 0; m8 = 0; or8 = 0;
    iv16 = 0; a16 = 0; b16 = 0; m16 = 0; or16 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("rst_in_ready", 32'(ir8), 1);
    chk("rst_out_valid", 32'(ov8), 0);
    chk("rst_res", 32'(r8), 0);
    chk("rst_err", 32'(e8), 0);
    chk("rst_exact", 32'(x8), 0);
    chk("rst_corr", 32'(c8), 0);
    for (int i = 0; i < 11; i++)
      op(0, vt[i].mode, {8'b0, vt[i].a}, {8'b0, vt[i].b}, {8'b0, vt[i].r},
         vt[i].e, vt[i].x, vt[i].c, vt[i].lat, $sformatf("vec%0d", i));
    op(1, 1, 16'h7FFF, 16'h0001, 17'h08000, 1, 1, 3'd5, 7, "w16_chain");
    // Hold the result while the consumer stalls; a second request must not be taken
    @(negedge clk);
    sel = 0; iv8 = 1; a8 = 8'h0F; b8 = 8'h01; m8 = 0;
    @(negedge clk);
    iv8 = 0;
    w = 0;
    while (!ov8 && w < 40) begin @(negedge clk); w++; end
    chk("hold_reach_done", 32'(ov8), 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_res", 32'(r8), 32'h010);
      chk("hold_ov", 32'(ov8), 1);
      chk("hold_in_ready", 32'(ir8), 0);
      chk("hold_flags", {29'b0, e8, x8, c8 != 0}, 32'b010);
      if (i == 2) begin iv8 = 1; a8 = 8'h55; b8 = 8'h55; m8 = 1; end
      if (i == 5) iv8 = 0;
      @(negedge clk);
    end
    or8 = 1;
    @(negedge clk);
    or8 = 0;
    chk("hold_release_idle", 32'(ir8), 1);
    chk("hold_release_ov", 32'(ov8), 0);
    repeat (4) @(negedge clk);
    chk("hold_no_extra_op", 32'(ov8), 0);
    chk("hold_res_kept", 32'(r8), 32'h010);
    // Reset in the middle of a long correction chain
    sel = 1; iv16 = 1; a16 = 16'h7FFF; b16 = 16'h0001; m16 = 1;
    @(negedge clk);
    iv16 = 0;
    repeat (2) @(negedge clk);
    chk("mid_corr_busy", 32'(ir16), 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst16_in_ready", 32'(ir16), 1);
    chk("rst16_out_valid", 32'(ov16), 0);
    chk("rst16_res", 32'(r16), 0);
    chk("rst16_err", 32'(e16), 0);
    chk("rst16_exact", 32'(x16), 0);
    chk("rst16_corr", 32'(c16), 0);
    op(1, 1, 16'h0001, 16'h0001, 17'h00002, 0, 1, 3'd0, 2, "after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
